// File: rtl/cpu_defs.sv
// cpu_defs: shared fetch FSM encodings, counter width and default datapath widths
package cpu_defs;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, VALID = 2'd3} fetch_state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of in (clk, reset, in -> pulse); a level held high through reset must fall before it can fire
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic q, armed;
  assign pulse = in & ~q & armed;
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
      armed <= 1'b0;
    end else begin
      q <= in;
      armed <= armed | ~in;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: step/run instruction fetcher (clk, reset, step_in, run, branch_valid/target, imem_addr/data, ir/ir_pc/ir_valid/ir_ready, pc, fetch_count)
module instr_fetch
  import cpu_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_in,
  input  logic              run,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       fetch_count
);
  fetch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n;
  logic step_pulse, step_pending, step_pending_n, capture, xfer;
  edge_detect u_edge (.clk(clk), .reset(reset), .in(step_in), .pulse(step_pulse));
  assign imem_addr = pc;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_n = branch_valid ? branch_target : pc;
    capture = 1'b0;
    xfer = 1'b0;
    unique case (state)
      IDLE: state_n = (run | step_pulse | step_pending) ? ISSUE : IDLE;
      ISSUE: begin
        state_n = branch_valid ? IDLE : WAIT;
        cnt_n = CNT_W'(IMEM_LATENCY - 1);
      end
      WAIT: begin
        capture = !branch_valid && cnt == '0;
        state_n = branch_valid ? IDLE : capture ? VALID : WAIT;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        if (capture) pc_n = pc + 1'b1;
      end
      VALID: begin
        xfer = ir_ready;
        state_n = ir_ready ? (run ? ISSUE : IDLE) : VALID;
      end
    endcase
    step_pending_n = (state_n == ISSUE && state != ISSUE) ? 1'b0
                   : step_pending | (step_pulse && state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pc <= RESET_PC;
      step_pending <= 1'b0;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc <= pc_n;
      step_pending <= step_pending_n;
      ir_valid <= state_n == VALID;
      if (capture) begin
        ir <= imem_data;
        ir_pc <= pc;
      end
      if (xfer) fetch_count <= fetch_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a 1-cycle imem model
module tb_instr_fetch;
  logic clk = 1'b0, reset, step_in, run, branch_valid, ir_valid, ir_ready;
  logic [15:0] branch_target, imem_addr, imem_data, ir, ir_pc, pc, fetch_count;
  int n_cmp = 0, n_bad = 0, xfers;
  instr_fetch dut (
    .clk(clk), .reset(reset), .step_in(step_in), .run(run),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] data_of(logic [15:0] a);
    return a == 16'h0 ? 16'hA5A5 : {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3};
  endfunction
  always @(posedge clk) imem_data <= data_of(imem_addr);
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    reset = 1'b1; step_in = 1'b0; run = 1'b0; branch_valid = 1'b0;
    branch_target = '0; ir_ready = 1'b0;
    tick(2);
    chk("rst_pc", pc, 16'h0);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_count", fetch_count, 16'h0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_irpc", ir_pc, 16'h0);
    reset = 1'b0;
    tick();
    step_in = 1'b1;
    tick(2);
    chk("step_early", ir_valid, 1'b0);
    tick();
    chk("step_valid", ir_valid, 1'b1);
    chk("step_ir", ir, 16'hA5A5);
    chk("step_irpc", ir_pc, 16'h0);
    chk("step_pc", pc, 16'h1);
    ir_ready = 1'b1;
    tick();
    chk("step_xfer", fetch_count, 16'h1);
    chk("step_drop", ir_valid, 1'b0);
    ir_ready = 1'b0; step_in = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run = 1'b1; ir_ready = 1'b1; xfers = 0;
    for (int i = 0; i < 31; i++) begin
      if (ir_valid) begin
        chk("run_irpc", ir_pc, xfers);
        chk("run_ir", ir, data_of(16'(xfers)));
        xfers++;
      end
      tick();
    end
    chk("run_xfers", xfers, 10);
    chk("run_count", fetch_count, 16'd10);
    run = 1'b0;
    tick(2);
    chk("runoff_valid", ir_valid, 1'b1);
    chk("runoff_irpc", ir_pc, 16'd10);
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ir", ir, data_of(16'd10));
      chk("hold_valid", ir_valid, 1'b1);
      chk("hold_count", fetch_count, 16'd10);
    end
    ir_ready = 1'b1;
    tick();
    chk("hold_xfer", fetch_count, 16'd11);
    chk("hold_drop", ir_valid, 1'b0);
    tick();
    chk("hold_once", fetch_count, 16'd11);
    ir_ready = 1'b0;
    step_in = 1'b1;
    tick(2);
    branch_valid = 1'b1; branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    chk("sq_pc", pc, 16'h0040);
    chk("sq_ir", ir, data_of(16'd10));
    chk("sq_valid", ir_valid, 1'b0);
    tick();
    chk("sq_valid2", ir_valid, 1'b0);
    step_in = 1'b0;
    tick();
    step_in = 1'b1;
    tick(3);
    chk("br_valid", ir_valid, 1'b1);
    chk("br_irpc", ir_pc, 16'h0040);
    chk("br_ir", ir, data_of(16'h0040));
    branch_valid = 1'b1; branch_target = 16'hFFFF;
    tick();
    branch_valid = 1'b0;
    chk("bv_pc", pc, 16'hFFFF);
    chk("bv_hold", ir_pc, 16'h0040);
    chk("bv_valid", ir_valid, 1'b1);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("bv_count", fetch_count, 16'd12);
    step_in = 1'b0;
    tick();
    step_in = 1'b1;
    tick(3);
    chk("wrap_irpc", ir_pc, 16'hFFFF);
    chk("wrap_ir", ir, data_of(16'hFFFF));
    chk("wrap_pc", pc, 16'h0000);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0; step_in = 1'b0;
    tick();
    step_in = 1'b1;
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_pc", pc, 16'h0);
    chk("mrst_ir", ir, 16'h0);
    chk("mrst_irpc", ir_pc, 16'h0);
    chk("mrst_valid", ir_valid, 1'b0);
    chk("mrst_count", fetch_count, 16'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("held_valid", ir_valid, 1'b0);
      chk("held_pc", pc, 16'h0);
    end
    step_in = 1'b0;
    tick();
    step_in = 1'b1;
    tick(3);
    chk("refetch_valid", ir_valid, 1'b1);
    chk("refetch_irpc", ir_pc, 16'h0);
    chk("refetch_ir", ir, 16'hA5A5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
